sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's 8x8 synchronous FIFO. Adds configurable width and depth, programmable almost-full/almost-empty thresholds, and an optional first-word-fall-through (FWFT) read mode. Adds sticky overflow/underflow error flags and defined same-cycle read/write behaviour at the full and empty boundaries. Sits between producer and consumer blocks in the same clock domain as a drop-in buffer.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 23 ++
 rtl/sync_fifo_param.sv | 85 ++++++++
 tb/tb_sync_fifo_param.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO family: default geometry, thresholds and read-mode selectors.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_AF_DEF    = FIFO_DEPTH_DEF - 2;
  localparam int FIFO_AE_DEF    = 2;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy needs one bit more than the pointers so that DEPTH itself is representable.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, sticky error flags and optional FWFT read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = FIFO_AE_DEF,
  parameter int FWFT     = FIFO_MODE_STD,
  localparam int CW = fifo_cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             w_en,
  input  logic             r_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    fifo_cnt,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             rd, wr;
  logic [WIDTH-1:0] mem_rdata;

  assign rd = r_en && !empty;
  // A full FIFO can still take a write when a read frees a slot in the same cycle.
  assign wr = w_en && (!full || rd);

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wptr),
    .wdata (data_in),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      cnt <= cnt + {{(CW-1){1'b0}}, wr} - {{(CW-1){1'b0}}, rd};
      if (w_en && !wr)  overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (r_en && !rd)  underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem_rdata;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  dout_q <= '0;
        else if (rd) dout_q <= mem_rdata;
      end
      assign data_out = dout_q;
    end
  endgenerate

  assign fifo_cnt     = cnt;
  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  assign almost_full  = (cnt >= CW'(AF_LEVEL));
  assign almost_empty = (cnt <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: standard and FWFT instances driven in lockstep against a queue model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = D - 2;
  localparam int AE = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;

  logic [W-1:0]  s_dout, f_dout;
  logic          s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
  logic          f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] s_cnt, f_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0, m_unf = 1'b0;
  logic [W-1:0] m_dout = '0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
    .data_out(s_dout), .empty(s_empty), .full(s_full), .almost_full(s_af), .almost_empty(s_ae),
    .fifo_cnt(s_cnt), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
    .data_out(f_dout), .empty(f_empty), .full(f_full), .almost_full(f_af), .almost_empty(f_ae),
    .fifo_cnt(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  function automatic logic [W-1:0] head();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  function automatic logic [CW-1:0] mcnt();
    return CW'(q.size());
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_dout = '0;
  endtask

  // One clock of stimulus; the model advances from the pre-edge state, outputs are sampled 1 time unit later.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    logic rd_ok, wr_ok;
    w_en = w; data_in = d; r_en = r; clr_err = c;
    rd_ok = r && (q.size() != 0);
    wr_ok = w && ((q.size() < D) || rd_ok);
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    m_ovf = (w && !wr_ok) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = (r && !rd_ok) ? 1'b1 : (c ? 1'b0 : m_unf);
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_cmp++; if (s_cnt !== '0)      begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", s_cnt); end
    n_cmp++; if (s_empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty: got %b expected 1", s_empty); end
    n_cmp++; if (s_full !== 1'b0)   begin n_fail++; $display("FAIL reset_full: got %b expected 0", s_full); end
    n_cmp++; if (s_ae !== 1'b1)     begin n_fail++; $display("FAIL reset_ae: got %b expected 1", s_ae); end
    n_cmp++; if (s_af !== 1'b0)     begin n_fail++; $display("FAIL reset_af: got %b expected 0", s_af); end
    n_cmp++; if ({s_ovf, s_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", s_ovf, s_unf); end
    n_cmp++; if (s_dout !== '0)     begin n_fail++; $display("FAIL reset_dout: got %h expected 00", s_dout); end
    n_cmp++; if (f_dout !== '0)     begin n_fail++; $display("FAIL reset_fwft_dout: got %h expected 00", f_dout); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= D; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0);
      n_cmp++; if (s_cnt !== CW'(i)) begin n_fail++; $display("FAIL fill_cnt[%0d]: got %0d expected %0d", i, s_cnt, i); end
      n_cmp++; if (s_af !== (i >= AF)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, s_af, (i >= AF)); end
      n_cmp++; if (s_ae !== (i <= AE)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, s_ae, (i <= AE)); end
    end
    n_cmp++; if (s_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", s_full); end
    step(1'b1, 8'd9, 1'b0, 1'b0);
    n_cmp++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", s_ovf); end
    n_cmp++; if (s_cnt !== CW'(D)) begin n_fail++; $display("FAIL overflow_cnt: got %0d expected %0d", s_cnt, D); end
    n_cmp++; if (f_ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_fwft: got %b expected 1", f_ovf); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= D; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (s_dout !== W'(i)) begin n_fail++; $display("FAIL drain_dout[%0d]: got %0d expected %0d", i, s_dout, i); end
      n_cmp++; if (f_dout !== head()) begin n_fail++; $display("FAIL drain_fwft_dout[%0d]: got %h expected %h", i, f_dout, head()); end
    end
    n_cmp++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", s_empty); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (s_unf !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b expected 1", s_unf); end
    n_cmp++; if (s_dout !== 8'd8) begin n_fail++; $display("FAIL underflow_hold: got %0d expected 8", s_dout); end
  endtask

  task automatic test_full_rw();
    step(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if ({s_ovf, s_unf} !== 2'b00) begin n_fail++; $display("FAIL clr_err: got %b%b expected 00", s_ovf, s_unf); end
    for (int i = 1; i <= D; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    step(1'b1, 8'd9, 1'b1, 1'b0);
    n_cmp++; if (s_dout !== 8'd1) begin n_fail++; $display("FAIL full_rw_dout: got %0d expected 1", s_dout); end
    n_cmp++; if (s_cnt !== CW'(D)) begin n_fail++; $display("FAIL full_rw_cnt: got %0d expected %0d", s_cnt, D); end
    n_cmp++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL full_rw_ovf: got %b expected 0", s_ovf); end
    for (int i = 2; i <= D + 1; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (s_dout !== W'(i)) begin n_fail++; $display("FAIL full_rw_pop[%0d]: got %0d expected %0d", i, s_dout, i); end
    end
  endtask

  task automatic test_empty_rw();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'd5, 1'b1, 1'b0);
    n_cmp++; if (s_cnt !== CW'(1)) begin n_fail++; $display("FAIL empty_rw_cnt: got %0d expected 1", s_cnt); end
    n_cmp++; if (s_unf !== 1'b1) begin n_fail++; $display("FAIL empty_rw_unf: got %b expected 1", s_unf); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (s_dout !== 8'd5) begin n_fail++; $display("FAIL empty_rw_pop: got %0d expected 5", s_dout); end
  endtask

  task automatic test_fwft();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    n_cmp++; if (f_dout !== 8'hA5) begin n_fail++; $display("FAIL fwft_show: got %h expected a5", f_dout); end
    n_cmp++; if (s_dout !== m_dout) begin n_fail++; $display("FAIL fwft_std_hold: got %h expected %h", s_dout, m_dout); end
    step(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_empty: got %b expected 1", f_empty); end
    n_cmp++; if (f_dout !== '0) begin n_fail++; $display("FAIL fwft_zero: got %h expected 00", f_dout); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] v;
    for (int i = 0; i < 2 * D; i++) begin
      v = W'($urandom);
      step(1'b1, v, (i >= 3), 1'b0);
      n_cmp++; if (s_dout !== m_dout) begin n_fail++; $display("FAIL wrap_dout[%0d]: got %h expected %h", i, s_dout, m_dout); end
      n_cmp++; if (f_dout !== head()) begin n_fail++; $display("FAIL wrap_fwft[%0d]: got %h expected %h", i, f_dout, head()); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (s_dout !== m_dout) begin n_fail++; $display("FAIL wrap_drain[%0d]: got %h expected %h", i, s_dout, m_dout); end
    end
  endtask

  task automatic test_random();
    logic w, r, c;
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 8);
      step(w, W'($urandom), r, c);
      n_cmp++; if (s_cnt !== mcnt()) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, s_cnt, mcnt()); end
      n_cmp++; if (s_dout !== m_dout) begin n_fail++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, s_dout, m_dout); end
      n_cmp++; if (f_dout !== head()) begin n_fail++; $display("FAIL rand_fwft[%0d]: got %h expected %h", i, f_dout, head()); end
      n_cmp++; if ({s_full, s_empty} !== {q.size() == D, q.size() == 0}) begin
        n_fail++; $display("FAIL rand_fe[%0d]: got %b%b expected %b%b", i, s_full, s_empty, q.size() == D, q.size() == 0); end
      n_cmp++; if ({s_af, s_ae} !== {q.size() >= AF, q.size() <= AE}) begin
        n_fail++; $display("FAIL rand_almost[%0d]: got %b%b expected %b%b", i, s_af, s_ae, q.size() >= AF, q.size() <= AE); end
      n_cmp++; if ({s_ovf, s_unf, f_ovf, f_unf} !== {m_ovf, m_unf, m_ovf, m_unf}) begin
        n_fail++; $display("FAIL rand_err[%0d]: got %b%b%b%b expected %b%b", i, s_ovf, s_unf, f_ovf, f_unf, m_ovf, m_unf); end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (s_cnt !== '0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d expected 0", s_cnt); end
    n_cmp++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset_empty: got %b expected 1", s_empty); end
    n_cmp++; if (f_dout !== '0) begin n_fail++; $display("FAIL mid_reset_fwft: got %h expected 00", f_dout); end
    #2;
    rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    n_cmp++; if (s_cnt !== CW'(1)) begin n_fail++; $display("FAIL post_reset_write: got %0d expected 1", s_cnt); end
    n_cmp++; if (f_dout !== 8'h3C) begin n_fail++; $display("FAIL post_reset_fwft: got %h expected 3c", f_dout); end
  endtask

  task automatic test_sticky_clear();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i <= D; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    n_cmp++; if ({s_ovf, s_unf} !== 2'b11) begin n_fail++; $display("FAIL sticky_set: got %b%b expected 11", s_ovf, s_unf); end
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    n_cmp++; if ({s_ovf, s_unf} !== 2'b10) begin n_fail++; $display("FAIL set_wins: got %b%b expected 10", s_ovf, s_unf); end
    step(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if ({s_ovf, s_unf, f_ovf, f_unf} !== 4'b0000) begin
      n_fail++; $display("FAIL clr_pulse: got %b%b%b%b expected 0000", s_ovf, s_unf, f_ovf, f_unf); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_rw();
        test_empty_rw();
        test_fwft();
        test_wrap();
        test_random();
        test_reset_midstream();
        test_sticky_clear();
      end
      begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got no completion expected completion within 200000 time units");
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
